// File: rtl/systolic_temp_pkg.sv
// systolic_temp_pkg: FSM state type and job-size helper shared by the systolic engine
package systolic_temp_pkg;
  typedef enum logic [2:0] {
    IDLE,
    WAITING_MEMORY_A,
    WAITING_MEMORY_B,
    EXECUTE,
    WRITEBACK,
    DONE
  } state_t;
  function automatic logic [3:0] eff_n(input logic [3:0] n, input logic [3:0] max_n);
    return (n == 4'd0 || n > max_n) ? max_n : n;
  endfunction
endpackage

// File: rtl/systolic_temp_pe.sv
// systolic_temp_pe: weight-stationary MAC cell; activations move right, partial sums move down
module systolic_temp_pe #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    w_ld,
  input  logic signed [WIDTH-1:0] w_in,
  input  logic signed [WIDTH-1:0] act_in,
  input  logic signed [WIDTH-1:0] psum_in,
  output logic signed [WIDTH-1:0] act_out,
  output logic signed [WIDTH-1:0] psum_out,
  output logic signed [WIDTH-1:0] weight
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      act_out  <= '0;
      psum_out <= '0;
      weight   <= '0;
    end else begin
      act_out  <= act_in;
      psum_out <= psum_in + act_in * weight;
      if (w_ld) weight <= w_in;
    end
endmodule

// File: rtl/systolic_temp.sv
// systolic_temp: NxN weight-stationary matrix multiplier with word-serial memory master
module systolic_temp
  import systolic_temp_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    new_data,
  input  logic signed [WIDTH-1:0] mem_read,
  input  logic [11:0]             addr_A,
  input  logic [11:0]             addr_B,
  input  logic [11:0]             addr_C,
  input  logic [3:0]              n,
  output logic                    mem_write,
  output logic signed [WIDTH-1:0] mem_data_write,
  output logic [11:0]             act_addr,
  output logic signed [WIDTH-1:0] weight_output [N][N],
  output logic signed [WIDTH-1:0] data_up [N],
  output logic signed [WIDTH-1:0] result_col [N],
  output state_t                  fsm_state,
  output logic [7:0]              cycle_count,
  output logic [31:0]             int_ops,
  output logic [3:0]              enable_out
);
  localparam int IW = $clog2(N);
  localparam logic [7:0] LAST_CYC = 8'(3 * N - 2);
  localparam logic [7:0] OPS_CYC = 8'(2 * N - 1);
  logic [11:0] base_a, base_b, base_c, idx, last_idx;
  logic [3:0] nn;
  logic [IW-1:0] r, c;
  logic step_last, row_end, start;
  logic signed [WIDTH-1:0] a_buf [N][N];
  logic signed [WIDTH-1:0] c_buf [N][N];
  logic signed [WIDTH-1:0] act_w [N][N+1];
  logic signed [WIDTH-1:0] ps_w [N+1][N];
  logic w_ld [N][N];
  logic signed [WIDTH-1:0] w_val;
  assign start = fsm_state == IDLE && new_data;
  assign last_idx = 12'(nn) * 12'(nn) - 12'd1;
  assign step_last = idx == last_idx;
  assign row_end = c == IW'(nn - 4'd1);
  assign w_val = fsm_state == WAITING_MEMORY_B ? mem_read : '0;
  assign enable_out = {fsm_state == WRITEBACK, fsm_state == EXECUTE,
                       fsm_state == WAITING_MEMORY_B, fsm_state == WAITING_MEMORY_A};
  assign mem_write = fsm_state == WRITEBACK;
  assign mem_data_write = mem_write ? c_buf[r][c] : '0;
  assign act_addr = fsm_state == WAITING_MEMORY_A ? base_a + idx :
                    fsm_state == WAITING_MEMORY_B ? base_b + idx :
                    mem_write ? base_c + idx : '0;
  // Row k sees A[i][k] at cycle i+k so each column's sum meets its operands in step
  always_comb begin
    for (int k = 0; k < N; k++) begin
      data_up[k] = '0;
      for (int i = 0; i < N; i++)
        if (fsm_state == EXECUTE && cycle_count == 8'(i + k)) data_up[k] = a_buf[i][k];
      for (int j = 0; j < N; j++)
        w_ld[k][j] = start || (fsm_state == WAITING_MEMORY_B && r == IW'(k) && c == IW'(j));
    end
  end
  for (genvar k = 0; k < N; k++) begin : g_row
    assign act_w[k][0] = data_up[k];
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_temp_pe #(.WIDTH(WIDTH)) u_pe (
        .clk     (clk),
        .rst     (rst),
        .w_ld    (w_ld[k][j]),
        .w_in    (w_val),
        .act_in  (act_w[k][j]),
        .psum_in (ps_w[k][j]),
        .act_out (act_w[k][j+1]),
        .psum_out(ps_w[k+1][j]),
        .weight  (weight_output[k][j])
      );
    end
  end
  for (genvar j = 0; j < N; j++) begin : g_edge
    assign ps_w[0][j] = '0;
    assign result_col[j] = ps_w[N][j];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      fsm_state   <= IDLE;
      base_a      <= '0;
      base_b      <= '0;
      base_c      <= '0;
      nn          <= '0;
      idx         <= '0;
      r           <= '0;
      c           <= '0;
      cycle_count <= '0;
      int_ops     <= '0;
      a_buf       <= '{default: '0};
      c_buf       <= '{default: '0};
    end else begin
      if (fsm_state inside {WAITING_MEMORY_A, WAITING_MEMORY_B, WRITEBACK}) begin
        idx <= step_last ? '0 : idx + 12'd1;
        r   <= step_last ? '0 : row_end ? r + 1'b1 : r;
        c   <= step_last || row_end ? '0 : c + 1'b1;
      end
      if (fsm_state == WAITING_MEMORY_A) a_buf[r][c] <= mem_read;
      if (fsm_state == EXECUTE) begin
        cycle_count <= cycle_count == LAST_CYC ? cycle_count : cycle_count + 8'd1;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            if (cycle_count == 8'(i + N + j)) c_buf[i][j] <= result_col[j];
        if (cycle_count >= OPS_CYC && cycle_count < OPS_CYC + 8'(nn))
          int_ops <= int_ops + 32'(nn) * 32'(nn);
      end
      case (fsm_state)
        IDLE: if (new_data) begin
          base_a    <= addr_A;
          base_b    <= addr_B;
          base_c    <= addr_C;
          nn        <= eff_n(n, 4'(N));
          a_buf     <= '{default: '0};
          fsm_state <= WAITING_MEMORY_A;
        end
        WAITING_MEMORY_A: if (step_last) fsm_state <= WAITING_MEMORY_B;
        WAITING_MEMORY_B: if (step_last) begin
          fsm_state   <= EXECUTE;
          cycle_count <= '0;
        end
        EXECUTE:   if (cycle_count == LAST_CYC) fsm_state <= WRITEBACK;
        WRITEBACK: if (step_last) fsm_state <= DONE;
        default:   fsm_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_systolic_temp.sv
// tb_systolic_temp: scoreboard bench for systolic_temp driving a behavioural word memory
module tb_systolic_temp;
  import systolic_temp_pkg::*;
  localparam int N = 4;
  typedef struct {
    logic [11:0]        addr;
    logic signed [15:0] data;
  } wr_t;
  logic clk = 0, rst = 0, new_data = 0;
  logic [11:0] addr_A = 0, addr_B = 0, addr_C = 0;
  logic [3:0] n = 0;
  logic signed [15:0] mem_read, mem_data_write;
  logic mem_write;
  logic [11:0] act_addr;
  logic signed [15:0] weight_output [N][N];
  logic signed [15:0] data_up [N];
  logic signed [15:0] result_col [N];
  state_t fsm_state;
  logic [7:0] cycle_count;
  logic [31:0] int_ops;
  logic [3:0] enable_out;
  logic signed [15:0] mem [4096];
  logic signed [15:0] ma [16];
  logic signed [15:0] mb [16];
  logic [11:0] rd_q [$];
  wr_t wr_q [$];
  int checks = 0, failures = 0, exec_cnt = 0, en_bad = 0, wr_cnt = 0;
  always #5 clk = ~clk;
  assign mem_read = mem[act_addr];
  systolic_temp #(.N(N), .WIDTH(16)) dut (
    .clk(clk), .rst(rst), .new_data(new_data), .mem_read(mem_read),
    .addr_A(addr_A), .addr_B(addr_B), .addr_C(addr_C), .n(n),
    .mem_write(mem_write), .mem_data_write(mem_data_write), .act_addr(act_addr),
    .weight_output(weight_output), .data_up(data_up), .result_col(result_col),
    .fsm_state(fsm_state), .cycle_count(cycle_count), .int_ops(int_ops),
    .enable_out(enable_out)
  );
  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (rst) begin
    logic [3:0] en_exp;
    wr_t e;
    en_exp = {fsm_state == WRITEBACK, fsm_state == EXECUTE,
              fsm_state == WAITING_MEMORY_B, fsm_state == WAITING_MEMORY_A};
    if (enable_out !== en_exp) en_bad++;
    if (fsm_state == EXECUTE) exec_cnt++;
    if (enable_out[0] || enable_out[1]) begin
      if (rd_q.size() == 0) check("rd_extra", act_addr, -1);
      else check("rd_addr", act_addr, rd_q.pop_front());
    end
    if (mem_write) begin
      wr_cnt++;
      mem[act_addr] = mem_data_write;
      if (wr_q.size() == 0) check("wr_extra", act_addr, -1);
      else begin
        e = wr_q.pop_front();
        check("wr_addr", act_addr, e.addr);
        check("wr_data", mem_data_write, e.data);
      end
    end
  end
  task automatic fill_rand();
    for (int i = 0; i < 16; i++) begin
      ma[i] = 16'($urandom);
      mb[i] = 16'($urandom);
    end
  endtask
  task automatic start_job(input logic [11:0] a, input logic [11:0] b, input logic [11:0] cc, input logic [3:0] nin);
    int ne, s;
    wr_t e;
    ne = (nin == 0 || nin > 4) ? 4 : int'(nin);
    for (int i = 0; i < ne * ne; i++) begin
      mem[a + 12'(i)] = ma[i];
      rd_q.push_back(a + 12'(i));
    end
    for (int i = 0; i < ne * ne; i++) begin
      mem[b + 12'(i)] = mb[i];
      rd_q.push_back(b + 12'(i));
    end
    for (int i = 0; i < ne; i++)
      for (int j = 0; j < ne; j++) begin
        s = 0;
        for (int k = 0; k < ne; k++) s += ma[i*ne+k] * mb[k*ne+j];
        e.addr = cc + 12'(i * ne + j);
        e.data = 16'(s);
        wr_q.push_back(e);
      end
    @(posedge clk); #1;
    addr_A = a; addr_B = b; addr_C = cc; n = nin; new_data = 1;
    @(posedge clk); #1;
    new_data = 0;
  endtask
  task automatic wait_state(input state_t st);
    int t;
    t = 0;
    while (fsm_state != st && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) check("timeout", fsm_state, st);
  endtask
  task automatic wait_done();
    wait_state(DONE);
    @(negedge clk);
    check("back_idle", fsm_state, IDLE);
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 0;
    repeat (3) @(negedge clk);
    check("rst_state", fsm_state, IDLE);
    check("rst_mem_write", mem_write, 0);
    check("rst_act_addr", act_addr, 0);
    check("rst_int_ops", int_ops, 0);
    check("rst_weight", weight_output[2][1], 0);
    @(posedge clk); #1 rst = 1;
    for (int i = 0; i < 16; i++) begin
      ma[i] = 16'(i + 1);
      mb[i] = 16'(2 * (i + 1));
    end
    exec_cnt = 0;
    start_job(16, 32, 48, 4);
    wait_done();
    check("exec_cycles", exec_cnt, 11);
    check("ops_job1", int_ops, 64);
    check("c0", mem[48], 180);
    check("c1", mem[49], 200);
    check("c3", mem[51], 240);
    check("c15", mem[63], 1200);
    check("w00", weight_output[0][0], 2);
    check("w33", weight_output[3][3], 32);
    check("rdq_drained", rd_q.size(), 0);
    check("wrq_drained", wr_q.size(), 0);
    fill_rand();
    wr_cnt = 0;
    start_job(200, 300, 400, 4);
    wait_state(EXECUTE);
    new_data = 1;
    @(negedge clk);
    new_data = 0;
    wait_done();
    repeat (5) @(negedge clk);
    check("ignored_start_writes", wr_cnt, 16);
    check("ignored_start_idle", fsm_state, IDLE);
    check("ops_job2", int_ops, 128);
    ma[0] = 1; ma[1] = 2; ma[2] = 3; ma[3] = 4;
    mb[0] = 5; mb[1] = 6; mb[2] = 7; mb[3] = 8;
    wr_cnt = 0;
    start_job(500, 600, 700, 2);
    wait_done();
    check("n2_c0", mem[700], 19);
    check("n2_c1", mem[701], 22);
    check("n2_c2", mem[702], 43);
    check("n2_c3", mem[703], 50);
    check("n2_writes", wr_cnt, 4);
    check("n2_w00", weight_output[0][0], 5);
    check("n2_w33_clear", weight_output[3][3], 0);
    check("ops_job3", int_ops, 136);
    fill_rand();
    start_job(1000, 1100, 1200, 0);
    wait_done();
    fill_rand();
    start_job(1300, 1400, 1500, 3);
    wait_done();
    check("ops_n0_n3", int_ops, 227);
    for (int i = 0; i < 16; i++) begin
      ma[i] = 16'h4000;
      mb[i] = 16'h4000;
    end
    start_job(2000, 2100, 2200, 9);
    wait_done();
    check("ovf_c0", mem[2200], 0);
    check("ovf_c15", mem[2215], 0);
    check("ops_ovf", int_ops, 291);
    check("queues_drained", rd_q.size() + wr_q.size(), 0);
    fill_rand();
    start_job(3000, 3100, 3200, 4);
    wait_state(WRITEBACK);
    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    check("abort_state", fsm_state, IDLE);
    check("abort_mem_write", mem_write, 0);
    check("abort_act_addr", act_addr, 0);
    check("abort_int_ops", int_ops, 0);
    rd_q.delete();
    wr_q.delete();
    wr_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (30) @(negedge clk);
    check("abort_no_writes", wr_cnt, 0);
    check("abort_idle", fsm_state, IDLE);
    check("enable_phases", en_bad, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
